// File: rtl/pe_periph_pkg.sv
// Shared types for the PE peripheral register responder:
// AXI channel structs, FSM states, burst/resp codes.
package pe_periph_pkg;

   localparam int unsigned PkgAddrWidth = 32;
   localparam int unsigned PkgDataWidth = 64;
   localparam int unsigned PkgIdWidth   = 4;

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_e;

   typedef enum logic [0:0] {
      R_IDLE,
      R_DATA
   } rd_state_e;

   typedef struct packed {
      logic [PkgIdWidth-1:0]   id;
      logic [PkgAddrWidth-1:0] addr;
      logic [7:0]              len;
      logic [2:0]              size;
      logic [1:0]              burst;
      logic [5:0]              atop;
   } aw_chan_t;

   typedef struct packed {
      logic [PkgDataWidth-1:0]   data;
      logic [PkgDataWidth/8-1:0] strb;
      logic                      last;
   } w_chan_t;

   typedef struct packed {
      logic [PkgIdWidth-1:0] id;
      logic [1:0]            resp;
   } b_chan_t;

   typedef struct packed {
      logic [PkgIdWidth-1:0]   id;
      logic [PkgAddrWidth-1:0] addr;
      logic [7:0]              len;
      logic [2:0]              size;
      logic [1:0]              burst;
   } ar_chan_t;

   typedef struct packed {
      logic [PkgIdWidth-1:0]   id;
      logic [PkgDataWidth-1:0] data;
      logic [1:0]              resp;
      logic                    last;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } axi_resp_t;

   function automatic int unsigned idx_width(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pe_periph_burst_addr.sv
// Per-beat address decode: register index, window check
// and next beat address for FIXED/INCR bursts.
module pe_periph_burst_addr
   import pe_periph_pkg::*;
#(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned NumRegs   = 16,
   parameter int unsigned IdxW      = idx_width(NumRegs)
) (
   input  logic [AddrWidth-1:0] addr,
   input  logic [AddrWidth-1:0] base,
   input  logic [1:0]           burst,
   output logic [AddrWidth-1:0] next_addr,
   output logic                 in_range,
   output logic [IdxW-1:0]      idx
);

   localparam int unsigned OffBits = $clog2(DataWidth/8);
   localparam logic [AddrWidth-1:0] Step = AddrWidth'(DataWidth/8);
   localparam logic [AddrWidth-1:0] Regs = AddrWidth'(NumRegs);

   logic [AddrWidth-1:0] off;
   logic [AddrWidth-1:0] idx_full;

   // offset into the window, range check, and burst step
   always_comb begin
      off       = addr - base;
      idx_full  = off >> OffBits;
      in_range  = (addr >= base) && (idx_full < Regs);
      idx       = idx_full[IdxW-1:0];
      next_addr = (burst == BurstIncr) ? addr + Step : addr;
   end

endmodule

// File: rtl/pe_periph_axi_regs.sv
// AXI4 register-bank responder for the PE NoC peripheral port,
// with independent write and read engines.
module pe_periph_axi_regs
   import pe_periph_pkg::*;
#(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned NumRegs   = 16,
   parameter type         req_t     = axi_req_t,
   parameter type         resp_t    = axi_resp_t
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [AddrWidth-1:0]               base_addr_i,
   input  req_t                               slv_req_i,
   output resp_t                              slv_resp_o,
   output logic [NumRegs-1:0][DataWidth-1:0]  reg_q_o,
   output logic [NumRegs-1:0]                 reg_wr_o
);

   localparam int unsigned IdxW  = idx_width(NumRegs);
   localparam int unsigned StrbW = DataWidth/8;

   wr_state_e wr_state, wr_next;
   rd_state_e rd_state, rd_next;

   logic [NumRegs-1:0][DataWidth-1:0] regs;
   logic [NumRegs-1:0]                reg_wr;

   logic                 aw_ready, w_ready, b_valid;
   logic                 ar_ready, r_valid;

   logic [IdWidth-1:0]   wr_id;
   logic [AddrWidth-1:0] wr_addr, wr_next_addr;
   logic [7:0]           wr_len, wr_cnt;
   logic [1:0]           wr_burst;
   logic                 wr_bad, wr_err, wr_in_range;
   logic [IdxW-1:0]      wr_idx;

   logic [IdWidth-1:0]   rd_id;
   logic [AddrWidth-1:0] rd_addr, rd_next_addr, rd_dec_addr;
   logic [7:0]           rd_len, rd_cnt;
   logic [1:0]           rd_burst, rd_dec_burst;
   logic                 rd_bad, rd_in_range, rd_beat_bad;
   logic [IdxW-1:0]      rd_idx;
   logic [DataWidth-1:0] r_data;
   logic [1:0]           r_resp;
   logic                 r_last;

   logic aw_hs, w_hs, ar_hs, r_hs;
   logic aw_bad, ar_bad, wr_beat_bad;
   logic unused_ok;

   assign aw_hs  = slv_req_i.aw_valid && aw_ready;
   assign w_hs   = slv_req_i.w_valid && w_ready;
   assign ar_hs  = slv_req_i.ar_valid && ar_ready;
   assign r_hs   = slv_req_i.r_ready && r_valid;

   assign aw_bad = !(slv_req_i.aw.burst == BurstFixed ||
                     slv_req_i.aw.burst == BurstIncr) ||
                   (slv_req_i.aw.atop != '0);
   assign ar_bad = !(slv_req_i.ar.burst == BurstFixed ||
                     slv_req_i.ar.burst == BurstIncr);

   assign wr_beat_bad = wr_bad || !wr_in_range;

   // read decode looks at AR while idle so beat 0 is sampled on handshake
   assign rd_dec_addr  = (rd_state == R_IDLE) ? slv_req_i.ar.addr : rd_addr;
   assign rd_dec_burst = (rd_state == R_IDLE) ? slv_req_i.ar.burst : rd_burst;
   assign rd_beat_bad  = ((rd_state == R_IDLE) ? ar_bad : rd_bad) || !rd_in_range;

   // size and w.last carry no information here: beat count governs
   assign unused_ok = ^{slv_req_i.aw.size, slv_req_i.ar.size, slv_req_i.w.last};

   pe_periph_burst_addr #(
      .AddrWidth (AddrWidth),
      .DataWidth (DataWidth),
      .NumRegs   (NumRegs),
      .IdxW      (IdxW)
   ) u_wr_dec (
      .addr      (wr_addr),
      .base      (base_addr_i),
      .burst     (wr_burst),
      .next_addr (wr_next_addr),
      .in_range  (wr_in_range),
      .idx       (wr_idx)
   );

   pe_periph_burst_addr #(
      .AddrWidth (AddrWidth),
      .DataWidth (DataWidth),
      .NumRegs   (NumRegs),
      .IdxW      (IdxW)
   ) u_rd_dec (
      .addr      (rd_dec_addr),
      .base      (base_addr_i),
      .burst     (rd_dec_burst),
      .next_addr (rd_next_addr),
      .in_range  (rd_in_range),
      .idx       (rd_idx)
   );

   // FSM state registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_state <= W_IDLE;
         rd_state <= R_IDLE;
      end else begin
         wr_state <= wr_next;
         rd_state <= rd_next;
      end
   end

   // write FSM next state and channel readies
   always_comb begin
      wr_next  = wr_state;
      aw_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      unique case (wr_state)
         W_IDLE: begin
            aw_ready = 1'b1;
            if (slv_req_i.aw_valid) wr_next = W_DATA;
         end
         W_DATA: begin
            w_ready = 1'b1;
            if (slv_req_i.w_valid && wr_cnt == wr_len) wr_next = W_RESP;
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (slv_req_i.b_ready) wr_next = W_IDLE;
         end
         default: wr_next = W_IDLE;
      endcase
   end

   // read FSM next state and channel valids
   always_comb begin
      rd_next  = rd_state;
      ar_ready = 1'b0;
      r_valid  = 1'b0;
      unique case (rd_state)
         R_IDLE: begin
            ar_ready = 1'b1;
            if (slv_req_i.ar_valid) rd_next = R_DATA;
         end
         R_DATA: begin
            r_valid = 1'b1;
            if (slv_req_i.r_ready && r_last) rd_next = R_IDLE;
         end
         default: rd_next = R_IDLE;
      endcase
   end

   // write burst tracking: address, beat count, sticky error
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_id    <= '0;
         wr_addr  <= '0;
         wr_len   <= '0;
         wr_burst <= '0;
         wr_bad   <= 1'b0;
         wr_err   <= 1'b0;
         wr_cnt   <= '0;
      end else if (aw_hs) begin
         wr_id    <= slv_req_i.aw.id;
         wr_addr  <= slv_req_i.aw.addr;
         wr_len   <= slv_req_i.aw.len;
         wr_burst <= slv_req_i.aw.burst;
         wr_bad   <= aw_bad;
         wr_err   <= 1'b0;
         wr_cnt   <= '0;
      end else if (w_hs) begin
         wr_addr <= wr_next_addr;
         wr_err  <= wr_err | wr_beat_bad;
         if (wr_cnt != wr_len) wr_cnt <= wr_cnt + 8'd1;
      end
   end

   // register bank with byte strobes and one-cycle write pulses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         regs   <= '0;
         reg_wr <= '0;
      end else begin
         reg_wr <= '0;
         if (w_hs && !wr_beat_bad) begin
            for (int b = 0; b < StrbW; b++) begin
               if (slv_req_i.w.strb[b]) regs[wr_idx][8*b +: 8] <= slv_req_i.w.data[8*b +: 8];
            end
            reg_wr[wr_idx] <= 1'b1;
         end
      end
   end

   // read burst: sample the beat on AR and on every accepted R beat
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_id    <= '0;
         rd_addr  <= '0;
         rd_len   <= '0;
         rd_burst <= '0;
         rd_bad   <= 1'b0;
         rd_cnt   <= '0;
         r_data   <= '0;
         r_resp   <= RespOkay;
         r_last   <= 1'b0;
      end else if (ar_hs) begin
         rd_id    <= slv_req_i.ar.id;
         rd_addr  <= rd_next_addr;
         rd_len   <= slv_req_i.ar.len;
         rd_burst <= slv_req_i.ar.burst;
         rd_bad   <= ar_bad;
         rd_cnt   <= '0;
         r_last   <= (slv_req_i.ar.len == 8'd0);
         r_data   <= rd_beat_bad ? '0 : regs[rd_idx];
         r_resp   <= rd_beat_bad ? RespSlvErr : RespOkay;
      end else if (r_hs && !r_last) begin
         rd_addr <= rd_next_addr;
         rd_cnt  <= rd_cnt + 8'd1;
         r_last  <= ((rd_cnt + 8'd1) == rd_len);
         r_data  <= rd_beat_bad ? '0 : regs[rd_idx];
         r_resp  <= rd_beat_bad ? RespSlvErr : RespOkay;
      end
   end

   // response struct packing
   always_comb begin
      slv_resp_o          = '0;
      slv_resp_o.aw_ready = aw_ready;
      slv_resp_o.w_ready  = w_ready;
      slv_resp_o.b_valid  = b_valid;
      slv_resp_o.b.id     = wr_id;
      slv_resp_o.b.resp   = wr_err ? RespSlvErr : RespOkay;
      slv_resp_o.ar_ready = ar_ready;
      slv_resp_o.r_valid  = r_valid;
      slv_resp_o.r.id     = rd_id;
      slv_resp_o.r.data   = r_data;
      slv_resp_o.r.resp   = r_resp;
      slv_resp_o.r.last   = r_last;
   end

   assign reg_q_o  = regs;
   assign reg_wr_o = reg_wr;

endmodule

// File: tb/tb_pe_periph_axi_regs.sv
// Directed bench for pe_periph_axi_regs: single/strobe/burst
// writes, stalled reads, range errors, concurrency, mid-burst reset.
module tb_pe_periph_axi_regs;
   import pe_periph_pkg::*;

   localparam logic [31:0] Base = 32'h4000_0000;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   axi_req_t             req;
   axi_resp_t            resp;
   logic [15:0][63:0]    reg_q;
   logic [15:0]          reg_wr;

   int total = 0;
   int bad = 0;

   logic [63:0] wr_data [8];
   logic [7:0]  wr_strb [8];
   logic [63:0] rd_data [8];
   logic [1:0]  rd_resp [8];
   logic        rd_last [8];
   logic [3:0]  rd_id   [8];
   int          pulses  [16];

   pe_periph_axi_regs dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .base_addr_i (Base),
      .slv_req_i   (req),
      .slv_resp_o  (resp),
      .reg_q_o     (reg_q),
      .reg_wr_o    (reg_wr)
   );

   always #5 clk = ~clk;

   initial for (int i = 0; i < 16; i++) pulses[i] = 0;

   always @(negedge clk) begin
      for (int i = 0; i < 16; i++) if (reg_wr[i]) pulses[i] = pulses[i] + 1;
   end

   task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [5:0] atop,
                            input logic [3:0] id, output logic [1:0] bresp,
                            output logic [3:0] bid, output logic [15:0] snap,
                            output int bwait, output bit to);
      int n;
      to = 0; bresp = '0; bid = '0; snap = '0; bwait = 0;
      req.aw.id = id; req.aw.addr = addr; req.aw.len = len;
      req.aw.size = 3'd3; req.aw.burst = burst; req.aw.atop = atop;
      req.aw_valid = 1'b1;
      n = 0;
      while (!resp.aw_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) to = 1;
      @(posedge clk); #1;
      req.aw_valid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         req.w.data = wr_data[i];
         req.w.strb = wr_strb[i];
         req.w.last = (i == int'(len));
         req.w_valid = 1'b1;
         n = 0;
         while (!resp.w_ready && n < 50) begin @(posedge clk); #1; n++; end
         if (n >= 50) to = 1;
         @(posedge clk); #1;
         snap = reg_wr;
      end
      req.w_valid = 1'b0;
      req.b_ready = 1'b1;
      n = 0;
      while (!resp.b_valid && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) to = 1;
      bwait = n;
      bresp = resp.b.resp;
      bid = resp.b.id;
      @(posedge clk); #1;
      req.b_ready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id,
                           input bit stall, output int unstable, output bit to);
      int n, cnt;
      bit holding;
      logic [63:0] hold_data;
      logic hold_last;
      to = 0; unstable = 0; cnt = 0; holding = 0;
      hold_data = '0; hold_last = 1'b0;
      req.ar.id = id; req.ar.addr = addr; req.ar.len = len;
      req.ar.size = 3'd3; req.ar.burst = burst;
      req.ar_valid = 1'b1;
      n = 0;
      while (!resp.ar_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) to = 1;
      @(posedge clk); #1;
      req.ar_valid = 1'b0;
      n = 0;
      while (cnt <= int'(len) && n < 300) begin
         req.r_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (resp.r_valid) begin
            if (holding && (resp.r.data !== hold_data || resp.r.last !== hold_last))
               unstable++;
            if (req.r_ready) begin
               rd_data[cnt] = resp.r.data;
               rd_resp[cnt] = resp.r.resp;
               rd_last[cnt] = resp.r.last;
               rd_id[cnt] = resp.r.id;
               cnt++;
               holding = 0;
            end else begin
               holding = 1;
               hold_data = resp.r.data;
               hold_last = resp.r.last;
            end
         end
         @(posedge clk); #1;
         n++;
      end
      if (cnt <= int'(len)) to = 1;
      req.r_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (reg_q !== '0) begin bad++; $display("FAIL reset_regs: got %h want 0", reg_q); end
      total++;
      if ({resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid} !== 5'b11000) begin
         bad++;
         $display("FAIL reset_hs: got %b want 11000",
                  {resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid});
      end
      total++;
      if (reg_wr !== '0) begin bad++; $display("FAIL reset_wr: got %h want 0", reg_wr); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_write();
      logic [1:0] br; logic [3:0] bi; logic [15:0] snap; int bw; bit to;
      int p1;
      p1 = pulses[1];
      wr_data[0] = 64'hDEAD_BEEF_0123_4567; wr_strb[0] = 8'hFF;
      axi_write(Base + 32'h8, 8'd0, BurstIncr, 6'd0, 4'd5, br, bi, snap, bw, to);
      @(posedge clk); #1;
      total++;
      if (to !== 1'b0) begin bad++; $display("FAIL single_timeout: got %0d want 0", to); end
      total++;
      if (reg_q[1] !== 64'hDEAD_BEEF_0123_4567) begin
         bad++; $display("FAIL single_reg1: got %h want deadbeef01234567", reg_q[1]);
      end
      total++;
      if (snap !== 16'h0002) begin bad++; $display("FAIL single_pulse: got %h want 0002", snap); end
      total++;
      if (pulses[1] - p1 !== 1) begin
         bad++; $display("FAIL single_pulse_cnt: got %0d want 1", pulses[1] - p1);
      end
      total++;
      if (br !== RespOkay || bi !== 4'd5) begin
         bad++; $display("FAIL single_b: got resp %0d id %0d want 0 5", br, bi);
      end
      total++;
      if (bw !== 0) begin bad++; $display("FAIL single_b_lat: got %0d want 0", bw); end
   endtask

   task automatic test_incr_read();
      logic [1:0] br; logic [3:0] bi; logic [15:0] snap; int bw; bit to; int us;
      logic [63:0] exp [4];
      wr_data[0] = 64'h1111_0000_0000_0001; wr_strb[0] = 8'hFF;
      axi_write(Base, 8'd0, BurstIncr, 6'd0, 4'd1, br, bi, snap, bw, to);
      wr_data[0] = 64'h3333_3333_3333_3333;
      axi_write(Base + 32'h18, 8'd0, BurstIncr, 6'd0, 4'd1, br, bi, snap, bw, to);
      exp[0] = 64'h1111_0000_0000_0001;
      exp[1] = 64'hDEAD_BEEF_0123_4567;
      exp[2] = 64'h0;
      exp[3] = 64'h3333_3333_3333_3333;
      axi_read(Base, 8'd3, BurstIncr, 4'd9, 1'b1, us, to);
      total++;
      if (to !== 1'b0) begin bad++; $display("FAIL incr_timeout: got %0d want 0", to); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (rd_data[i] !== exp[i] || rd_resp[i] !== RespOkay ||
             rd_last[i] !== (i == 3) || rd_id[i] !== 4'd9) begin
            bad++;
            $display("FAIL incr_beat%0d: got %h/%0d/%0d/%0d want %h/0/%0d/9",
                     i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], exp[i], (i == 3));
         end
      end
      total++;
      if (us !== 0) begin bad++; $display("FAIL incr_stable: got %0d changes want 0", us); end
      total++;
      if (resp.r_valid !== 1'b0) begin bad++; $display("FAIL incr_extra: got r_valid 1 want 0"); end
   endtask

   task automatic test_strobe_write();
      logic [1:0] br; logic [3:0] bi; logic [15:0] snap; int bw; bit to;
      wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF; wr_strb[0] = 8'h0F;
      axi_write(Base + 32'h10, 8'd0, BurstIncr, 6'd0, 4'd2, br, bi, snap, bw, to);
      total++;
      if (reg_q[2] !== 64'h0000_0000_FFFF_FFFF) begin
         bad++; $display("FAIL strb_low: got %h want 00000000ffffffff", reg_q[2]);
      end
      wr_data[0] = 64'hAB00_0000_0000_0000; wr_strb[0] = 8'h80;
      axi_write(Base + 32'h10, 8'd0, BurstFixed, 6'd0, 4'd2, br, bi, snap, bw, to);
      total++;
      if (reg_q[2] !== 64'hAB00_0000_FFFF_FFFF) begin
         bad++; $display("FAIL strb_top: got %h want ab000000ffffffff", reg_q[2]);
      end
   endtask

   task automatic test_fixed_burst();
      logic [1:0] br; logic [3:0] bi; logic [15:0] snap; int bw; bit to;
      int p4, p5;
      p4 = pulses[4]; p5 = pulses[5];
      wr_data[0] = 64'hA0; wr_data[1] = 64'hA1; wr_data[2] = 64'hA2;
      wr_strb[0] = 8'hFF; wr_strb[1] = 8'hFF; wr_strb[2] = 8'hFF;
      axi_write(Base + 32'h20, 8'd2, BurstFixed, 6'd0, 4'd7, br, bi, snap, bw, to);
      @(posedge clk); #1;
      total++;
      if (reg_q[4] !== 64'hA2 || reg_q[5] !== 64'h0) begin
         bad++; $display("FAIL fixed_regs: got %h %h want a2 0", reg_q[4], reg_q[5]);
      end
      total++;
      if (pulses[4] - p4 !== 3 || pulses[5] - p5 !== 0 || br !== RespOkay) begin
         bad++;
         $display("FAIL fixed_pulses: got %0d %0d resp %0d want 3 0 0",
                  pulses[4] - p4, pulses[5] - p5, br);
      end
   endtask

   task automatic test_out_of_range();
      logic [1:0] br; logic [3:0] bi; logic [15:0] snap; int bw; bit to; int us;
      int tot_before, tot_after;
      tot_before = 0;
      for (int i = 0; i < 16; i++) tot_before += pulses[i];
      wr_data[0] = 64'h0F0F_0F0F_0F0F_0F0F; wr_data[1] = 64'h1234_5678_9ABC_DEF0;
      wr_strb[0] = 8'hFF; wr_strb[1] = 8'hFF;
      axi_write(Base + 32'h78, 8'd1, BurstIncr, 6'd0, 4'd3, br, bi, snap, bw, to);
      @(posedge clk); #1;
      tot_after = 0;
      for (int i = 0; i < 16; i++) tot_after += pulses[i];
      total++;
      if (reg_q[15] !== 64'h0F0F_0F0F_0F0F_0F0F) begin
         bad++; $display("FAIL oor_reg15: got %h want 0f0f0f0f0f0f0f0f", reg_q[15]);
      end
      total++;
      if (br !== RespSlvErr || bi !== 4'd3) begin
         bad++; $display("FAIL oor_bresp: got %0d id %0d want 2 3", br, bi);
      end
      total++;
      if (tot_after - tot_before !== 1 || reg_q[0] !== 64'h1111_0000_0000_0001) begin
         bad++;
         $display("FAIL oor_side: got %0d pulses reg0 %h want 1 1111000000000001",
                  tot_after - tot_before, reg_q[0]);
      end
      axi_read(Base - 32'h8, 8'd0, BurstIncr, 4'd4, 1'b0, us, to);
      total++;
      if (rd_data[0] !== 64'h0 || rd_resp[0] !== RespSlvErr || rd_last[0] !== 1'b1) begin
         bad++;
         $display("FAIL oor_read: got %h/%0d/%0d want 0/2/1", rd_data[0], rd_resp[0], rd_last[0]);
      end
   endtask

   task automatic test_concurrency();
      logic [1:0] br; logic [3:0] bi; logic [15:0] snap; int bw; bit to; int us;
      logic both_ready;
      req.aw.id = 4'd2; req.aw.addr = Base + 32'h18; req.aw.len = 8'd0;
      req.aw.size = 3'd3; req.aw.burst = BurstIncr; req.aw.atop = 6'd0;
      req.aw_valid = 1'b1;
      @(posedge clk); #1;
      req.aw_valid = 1'b0;
      req.w.data = 64'h5555_5555_5555_5555; req.w.strb = 8'hFF; req.w.last = 1'b1;
      req.w_valid = 1'b1;
      req.ar.id = 4'd6; req.ar.addr = Base + 32'h18; req.ar.len = 8'd0;
      req.ar.size = 3'd3; req.ar.burst = BurstIncr;
      req.ar_valid = 1'b1;
      both_ready = resp.w_ready && resp.ar_ready;
      @(posedge clk); #1;
      req.w_valid = 1'b0; req.ar_valid = 1'b0;
      total++;
      if (both_ready !== 1'b1) begin bad++; $display("FAIL conc_same_cycle: got %0d want 1", both_ready); end
      total++;
      if (resp.r_valid !== 1'b1 || resp.r.data !== 64'h3333_3333_3333_3333 || resp.r.last !== 1'b1) begin
         bad++;
         $display("FAIL conc_old: got %0d/%h want 1/3333333333333333", resp.r_valid, resp.r.data);
      end
      total++;
      if (resp.b_valid !== 1'b1 || resp.b.resp !== RespOkay || resp.b.id !== 4'd2) begin
         bad++;
         $display("FAIL conc_b: got %0d/%0d/%0d want 1/0/2", resp.b_valid, resp.b.resp, resp.b.id);
      end
      req.r_ready = 1'b1; req.b_ready = 1'b1;
      @(posedge clk); #1;
      req.r_ready = 1'b0; req.b_ready = 1'b0;
      axi_read(Base + 32'h18, 8'd0, BurstIncr, 4'd6, 1'b0, us, to);
      total++;
      if (rd_data[0] !== 64'h5555_5555_5555_5555 || to !== 1'b0) begin
         bad++; $display("FAIL conc_new: got %h want 5555555555555555", rd_data[0]);
      end
      wr_data[0] = 64'h77; wr_strb[0] = 8'hFF;
      axi_write(Base + 32'h28, 8'd0, BurstWrap, 6'd0, 4'd1, br, bi, snap, bw, to);
      total++;
      if (br !== RespSlvErr || reg_q[5] !== 64'h0 || snap !== 16'h0) begin
         bad++; $display("FAIL wrap_write: got %0d/%h/%h want 2/0/0", br, reg_q[5], snap);
      end
      axi_write(Base + 32'h30, 8'd0, BurstIncr, 6'h20, 4'd1, br, bi, snap, bw, to);
      total++;
      if (br !== RespSlvErr || reg_q[6] !== 64'h0 || snap !== 16'h0) begin
         bad++; $display("FAIL atop_write: got %0d/%h/%h want 2/0/0", br, reg_q[6], snap);
      end
      axi_read(Base, 8'd0, BurstWrap, 4'd1, 1'b0, us, to);
      total++;
      if (rd_data[0] !== 64'h0 || rd_resp[0] !== RespSlvErr) begin
         bad++; $display("FAIL wrap_read: got %h/%0d want 0/2", rd_data[0], rd_resp[0]);
      end
   endtask

   task automatic test_reset_mid_burst();
      req.ar.id = 4'd1; req.ar.addr = Base; req.ar.len = 8'd7;
      req.ar.size = 3'd3; req.ar.burst = BurstIncr;
      req.ar_valid = 1'b1;
      @(posedge clk); #1;
      req.ar_valid = 1'b0;
      req.r_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if (resp.r_valid !== 1'b1 || resp.r.data !== 64'h0000_0000_FFFF_FFFF && resp.r.data !== 64'hAB00_0000_FFFF_FFFF) begin
         bad++; $display("FAIL rst_beat2: got %0d/%h want 1/ab000000ffffffff", resp.r_valid, resp.r.data);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if (resp.r_valid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got 1 want 0"); end
      total++;
      if (reg_q !== '0 || reg_wr !== '0) begin
         bad++; $display("FAIL rst_regs: got %h want 0", reg_q);
      end
      total++;
      if ({resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid} !== 4'b1100) begin
         bad++;
         $display("FAIL rst_ready: got %b want 1100",
                  {resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid});
      end
      req.r_ready = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      req = '0;
      for (int i = 0; i < 8; i++) begin
         wr_data[i] = '0; wr_strb[i] = '0;
         rd_data[i] = '0; rd_resp[i] = '0; rd_last[i] = 1'b0; rd_id[i] = '0;
      end
      test_reset();
      test_single_write();
      test_incr_read();
      test_strobe_write();
      test_fixed_burst();
      test_out_of_range();
      test_concurrency();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
